// File: rtl/mod_updown_counter.sv
// Generic up/down counter: programmable modulus, wrap or saturate, clear, load, TC and Ovf flags.
// Define COUNTER_PRESCALE_EN to step only once every PRESCALE qualified count cycles.
module mod_updown_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Load,
  input  logic             count,
  input  logic             Up,
  input  logic [WIDTH-1:0] Count_in,
  output logic [WIDTH-1:0] Count_out,
  output logic             TC,
  output logic             Ovf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] w_countNext;
  logic             w_ovfNext;
  logic             w_step;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  assign w_inc = {1'b0, r_count} + (WIDTH+1)'(1);
  assign w_dec = {1'b0, r_count} - (WIDTH+1)'(1);

  assign TC        = Up ? (r_count == MAX_VAL) : (r_count == '0);
  assign Count_out = r_count;
  assign Ovf       = r_ovf;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_presc;
  logic [PS_W-1:0] w_prescNext;

  assign w_step = count && (r_presc == PS_LAST);

  always_comb begin
    w_prescNext = r_presc;
    if (Clear || Load) begin
      w_prescNext = '0;
    end else if (count) begin
      w_prescNext = w_step ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_prescNext;
    end
  end
`else
  // PRESCALE has no effect here; the guard only rejects a meaningless zero setting.
  assign w_step = count && (PRESCALE >= 1);
`endif

  always_comb begin
    w_countNext = r_count;
    w_ovfNext   = 1'b0;
    if (Clear) begin
      w_countNext = '0;
    end else if (Load) begin
      w_countNext = (Count_in > MAX_VAL) ? MAX_VAL : Count_in;
    end else if (w_step) begin
      if (TC) begin
        w_ovfNext = 1'b1;
        if (!SATURATE) begin
          w_countNext = Up ? '0 : MAX_VAL;
        end
      end else begin
        w_countNext = Up ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_ovf   <= w_ovfNext;
    end
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the toy-processor 8-bit load/count register. Generic-width up/down counter with programmable modulus, selectable wrap or saturate mode, synchronous clear, and terminal-count and overflow flags. Used as the program counter, loop counter and timer tick source in the ToyProcessor datapath.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, highest legal count value; the count range is 0..MAX_VAL
SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries
PRESCALE, 4, number of qualified count cycles per step; only used when COUNTER_PRESCALE_EN is defined (>=1)

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low; clears all state while low
Clear  input  1  synchronous clear to 0
Load  input  1  synchronous load of Count_in
count  input  1  count enable
Up  input  1  1 = increment, 0 = decrement
Count_in  input  WIDTH  load value
Count_out  output  WIDTH  current count (registered)
TC  output  1  terminal count, combinational: 1 when (Up & Count_out==MAX_VAL) | (!Up & Count_out==0)
Ovf  output  1  registered one-cycle pulse marking a boundary crossing or saturation hit

Behaviour:
- Reset low (asynchronous): Count_out=0, Ovf=0, prescaler=0. Release is sampled at the next CLK rise.
- Priority per rising edge: Clear > Load > count > hold.
- Clear: Count_out<=0, Ovf<=0, prescaler<=0.
- Load: Count_out<=min(Count_in, MAX_VAL), i.e. out-of-range values clamp to MAX_VAL. Ovf<=0, prescaler<=0. Load overrides a simultaneous count.
- count=1, not at boundary: Count_out<=Count_out+1 when Up=1, Count_out-1 when Up=0. Ovf<=0.
- count=1 at boundary (TC=1):
  - SATURATE=0: up wraps MAX_VAL->0; down wraps 0->MAX_VAL. Ovf<=1 for one cycle.
  - SATURATE=1: Count_out holds. Ovf<=1 every cycle the hold occurs while count stays high.
- count=0: hold, Ovf<=0.
- Latency: Count_out updates on the edge where the control is sampled. Ovf is valid the cycle after the crossing, aligned with the new Count_out. TC follows Count_out and Up combinationally in the same cycle.
- Up may change on any cycle; direction takes effect at the next edge.
- Arithmetic is internally WIDTH+1 bits. No value above MAX_VAL is ever stored (invariant).
- MAX_VAL=2**WIDTH-1 with wrap mode gives a natural binary rollover.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: an internal ceil(log2(PRESCALE))-bit prescaler increments on each count=1 cycle. The counter steps, and TC/Ovf boundary logic applies, only on the cycle the prescaler reaches PRESCALE-1; the prescaler then returns to 0.
  - count=0 freezes the prescaler.
  - Clear, Load and Reset zero the prescaler.
  - PRESCALE=1 behaves identically to the feature being undefined.
- Undefined: no prescaler logic. The counter steps on every count=1 cycle and PRESCALE is ignored.

Test Plan:
- Reset low mid-count (Count_out=0x37, count=1), asserted between edges -> Count_out=0x00 and Ovf=0 immediately, without waiting for CLK; counting resumes from 0 after release.
- Control priority, WIDTH=8: Count_in=0xFF, all 8 combinations of {Clear,Load,count}, one cycle each -> Clear gives 0x00; Load gives 0xFF; count-only increments by 1; all-low holds.
- Wrap up, WIDTH=8, SATURATE=0: Load 0xFB, count=1, Up=1 for 6 cycles -> FC, FD, FE, FF, 00, 01; Ovf high only on the cycle Count_out=0x00; TC high while Count_out=0xFF.
- Decimal modulus, MAX_VAL=9, SATURATE=0: Load 12 -> Count_out=9 (clamped). Up=0 for 11 cycles -> 8..0 then 9, 8; Ovf pulses once, with Count_out=9.
- Saturate, MAX_VAL=9, SATURATE=1: Load 8, Up=1, count=1 for 4 cycles -> 9, 9, 9, 9; Ovf=0 on the first cycle (8->9), then 1 on each of the three holds. Then Up=0 -> 8 next cycle, Ovf=0.
- COUNTER_PRESCALE_EN, PRESCALE=4: count=1 continuously from 0 -> Count_out steps on every 4th edge (0,0,0,1,1,1,1,2...). Dropping count for 2 cycles stretches the current step by 2 cycles.
